// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV data-memory slice: FSM state encoding,
// byte-enable patterns and the store-pattern legality check.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [3:0] WE_NONE = 4'b0000;
    localparam logic [3:0] WE_BYTE = 4'b0001;
    localparam logic [3:0] WE_HALF = 4'b0011;
    localparam logic [3:0] WE_WORD = 4'b1111;

    // A store is legal when its enables form a naturally aligned byte,
    // halfword or word at the given byte offset.
    function automatic logic we_legal(input logic [3:0] we, input logic [1:0] addr_lo);
        logic byte_ok;
        logic half_ok;
        logic word_ok;
        byte_ok = (we == (WE_BYTE << addr_lo));
        half_ok = !addr_lo[0] && (we == (WE_HALF << addr_lo));
        word_ok = (addr_lo == 2'd0) && (we == WE_WORD);
        return byte_ok || half_ok || word_ok;
    endfunction

endpackage

// File: rtl/rv_dmem_array.sv
// Word-organised data storage built from four independent byte-lane RAMs,
// each with its own write enable and a registered (synchronous) read port.
module rv_dmem_array
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] lane_q;

        // Byte-lane write and synchronous read; the read register holds
        // its value until the next read so it can be presented later.
        // NOTE: storage and its read register are deliberately not reset so
        // they map onto RAM macros; contents survive a reset.
        always_ff @(posedge clk) begin
            if (we[lane]) begin
                mem[idx] <= wdata[8*lane +: 8];
            end
            if (re) begin
                lane_q <= mem[idx];
            end
        end

        assign rdata[8*lane +: 8] = lane_q;
    end

endmodule

// File: rtl/rv_dmem.sv
// Single-port data memory with a valid/ready request side and a one-cycle
// response strobe. Stores commit on the accept edge; loads are read on the
// accept edge and presented in the response cycle.
// Optional feature: define RV_DMEM_WAIT_EN to insert WAIT_CYCLES wait states
// before each response; otherwise latency is fixed at one cycle.
module rv_dmem
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_we,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e state;
    logic        accept;
    logic        is_load;
    logic        addr_oob;
    logic        req_err;
    logic        do_write;
    logic        rsp_load_q;
    logic [31:0] ram_rdata;
    logic [31:0] rdata_hold_q;

`ifdef RV_DMEM_WAIT_EN
    logic [3:0]  wait_cnt;
    logic        err_q;
`else
    // WAIT_CYCLES has no effect when wait states are compiled out.
    logic [3:0]  wait_cycles_unused;
    assign wait_cycles_unused = 4'(WAIT_CYCLES);
`endif

    assign req_ready = !srst && (state != WAIT);
    assign accept    = req_valid && req_ready;
    assign is_load   = (req_we == WE_NONE);
    assign addr_oob  = |req_addr[31:AW+2];
    assign req_err   = addr_oob || (!is_load && !we_legal(req_we, req_addr[1:0]));
    assign do_write  = accept && !is_load && !req_err;

    rv_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (do_write ? req_we : WE_NONE),
        .re    (accept && is_load),
        .idx   (req_addr[AW+1:2]),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    // Live load data during the response cycle, last response value otherwise.
    assign rsp_rdata = rsp_valid ? (rsp_load_q ? ram_rdata : 32'd0) : rdata_hold_q;

    // Request/response FSM with registered response strobe and error flag.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (srst) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_load_q   <= 1'b0;
            rdata_hold_q <= 32'd0;
`ifdef RV_DMEM_WAIT_EN
            wait_cnt     <= 4'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            if (rsp_valid) begin
                rdata_hold_q <= rsp_rdata;
            end
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        rsp_load_q <= is_load && !req_err;
`ifdef RV_DMEM_WAIT_EN
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= 4'd0;
                            err_q    <= req_err;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_err;
                        end
`else
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= req_err;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
`ifdef RV_DMEM_WAIT_EN
                    if (wait_cnt == 4'(WAIT_CYCLES - 1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_dmem.sv
// Directed bench for rv_dmem. Two instances share one request bus: dut_w3
// (WAIT_CYCLES=3) for the latency/reset scenarios and dut_w0 (WAIT_CYCLES=0)
// for back-to-back throughput. sel chooses which instance sees req_valid.
module tb_rv_dmem;

    localparam int W3 = 3;
`ifdef RV_DMEM_WAIT_EN
    localparam int LAT3 = 1 + W3;
`else
    localparam int LAT3 = 1;
`endif
    localparam int LAT0 = 1;

    logic        clk = 1'b0;
    logic        srst;
    logic        sel;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_we;

    logic        ready3, ready0, rv3, rv0, err3, err0;
    logic [31:0] rd3, rd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_dmem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W3)) dut_w3 (
        .clk       (clk),
        .srst      (srst),
        .req_valid (req_valid && !sel),
        .req_ready (ready3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .rsp_valid (rv3),
        .rsp_rdata (rd3),
        .rsp_err   (err3)
    );

    rv_dmem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk       (clk),
        .srst      (srst),
        .req_valid (req_valid && sel),
        .req_ready (ready0),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .rsp_valid (rv0),
        .rsp_rdata (rd0),
        .rsp_err   (err0)
    );

    assign req_ready = sel ? ready0 : ready3;
    assign rsp_valid = sel ? rv0    : rv3;
    assign rsp_err   = sel ? err0   : err3;
    assign rsp_rdata = sel ? rd0    : rd3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One isolated request: checks ready, response latency, error/data, and
    // that the strobe drops while rsp_rdata holds on the following cycle.
    task automatic do_req(input string tag, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input logic exp_err,
                          input logic [31:0] exp_rdata);
        int k;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, ".lat"}, 32'(k), 32'(lat));
        check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
        @(posedge clk);
        #1;
        check({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, ".rdata_hold"}, rsp_rdata, exp_rdata);
    endtask

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t burst [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 4'b0000;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        srst      = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset.ready_low", 32'(req_ready), 32'd0);
        check("reset.valid", 32'(rsp_valid), 32'd0);
        check("reset.err", 32'(rsp_err), 32'd0);
        check("reset.rdata", rsp_rdata, 32'd0);
        srst = 1'b0;
        #1;
        check("reset.ready_high", 32'(req_ready), 32'd1);

        // Word store, load back
        do_req("st_word", 4'b1111, 32'h10, 32'hDEADBEEF, LAT3, 1'b0, 32'd0);
        do_req("ld_word", 4'b0000, 32'h10, 32'd0, LAT3, 1'b0, 32'hDEADBEEF);

        // Byte store into lane 2
        do_req("st_byte", 4'b0100, 32'h12, 32'h00AB0000, LAT3, 1'b0, 32'd0);
        do_req("ld_byte", 4'b0000, 32'h10, 32'd0, LAT3, 1'b0, 32'hDEABBEEF);

        // Misaligned halfword store is rejected; load offset bits ignored
        do_req("st_bad", 4'b0011, 32'h13, 32'hFFFFFFFF, LAT3, 1'b1, 32'd0);
        do_req("ld_after_bad", 4'b0000, 32'h13, 32'd0, LAT3, 1'b0, 32'hDEABBEEF);

        // Out-of-range load and store (0x1010 aliases word 0x10 if unchecked)
        do_req("ld_oob", 4'b0000, 32'h1000, 32'd0, LAT3, 1'b1, 32'd0);
        do_req("st_oob", 4'b1111, 32'h1010, 32'h0BADF00D, LAT3, 1'b1, 32'd0);

        // Legal upper halfword store
        do_req("st_half", 4'b1100, 32'h12, 32'h12340000, LAT3, 1'b0, 32'd0);
        do_req("ld_half", 4'b0000, 32'h10, 32'd0, LAT3, 1'b0, 32'h1234BEEF);

        // Zero-wait instance: preload, then a store followed by 4 back-to-back loads
        sel = 1'b1;
        do_req("w0_st20", 4'b1111, 32'h20, 32'h11112222, LAT0, 1'b0, 32'd0);
        do_req("w0_st24", 4'b1111, 32'h24, 32'h33334444, LAT0, 1'b0, 32'd0);
        burst[0] = '{we: 4'b1111, addr: 32'h28, wdata: 32'hCAFEF00D, exp_rdata: 32'd0};
        burst[1] = '{we: 4'b0000, addr: 32'h28, wdata: 32'd0, exp_rdata: 32'hCAFEF00D};
        burst[2] = '{we: 4'b0000, addr: 32'h20, wdata: 32'd0, exp_rdata: 32'h11112222};
        burst[3] = '{we: 4'b0000, addr: 32'h26, wdata: 32'd0, exp_rdata: 32'h33334444};
        burst[4] = '{we: 4'b0000, addr: 32'h24, wdata: 32'd0, exp_rdata: 32'h33334444};
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_we    = burst[i].we;
            req_addr  = burst[i].addr;
            req_wdata = burst[i].wdata;
            check($sformatf("b2b[%0d].ready", i), 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("b2b[%0d].valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("b2b[%0d].err", i), 32'(rsp_err), 32'd0);
            check($sformatf("b2b[%0d].rdata", i), rsp_rdata, burst[i].exp_rdata);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b.valid_drop", 32'(rsp_valid), 32'd0);
        check("b2b.rdata_hold", rsp_rdata, 32'h33334444);

        // Reset in the middle of a waiting load
        sel       = 1'b0;
        req_valid = 1'b1;
        req_we    = 4'b0000;
        req_addr  = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
`ifdef RV_DMEM_WAIT_EN
        check("rst_mid.wait_ready", 32'(req_ready), 32'd0);
        check("rst_mid.wait_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
`endif
        srst = 1'b1;
        #1;
        check("rst_mid.ready_in_srst", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid.valid", 32'(rsp_valid), 32'd0);
        check("rst_mid.err", 32'(rsp_err), 32'd0);
        check("rst_mid.rdata", rsp_rdata, 32'd0);
        check("rst_mid.ready_still_low", 32'(req_ready), 32'd0);
        srst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("rst_mid.no_response", 32'(seen), 32'd0);
        check("rst_mid.idle_ready", 32'(req_ready), 32'd1);
        do_req("rst_mid.data_kept", 4'b0000, 32'h10, 32'd0, LAT3, 1'b0, 32'h1234BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_dmem.md
RV_DMEM -- requirements
Module: rv_dmem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: memory size in 32-bit words, power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: extra response latency, range 0..15, used only under RV_DMEM_WAIT_EN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port srst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 SHALL have port req_wdata, input, 32 bits: store data, lane-positioned.
REQ-009 SHALL have port req_we, input, 4 bits: byte write enables; 4'b0000 means a load.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata, output, 32 bits: the full word read, for loads.
REQ-012 SHALL have port rsp_err, output, 1 bit: the request was rejected; valid with rsp_valid.

Function
REQ-013 SHALL accept a request on a rising edge where req_valid and req_ready are both high.
REQ-014 SHALL implement states IDLE, WAIT and RESP.
- IDLE to WAIT on accept when WAIT_CYCLES > 0.
- IDLE to RESP on accept otherwise.
- WAIT to RESP when the wait counter reaches WAIT_CYCLES-1.
- RESP to WAIT or RESP on a new accept, else to IDLE.
REQ-015 SHALL drive req_ready high in IDLE and RESP and low in WAIT.
REQ-016 SHALL assert rsp_valid for exactly one cycle, in RESP only; there is no response backpressure.
REQ-017 SHALL place the response 1+WAIT_CYCLES cycles after the accept edge, giving throughput of one request per cycle when WAIT_CYCLES=0.
REQ-018 SHALL index the memory with word index req_addr[log2(DEPTH_WORDS)+1:2].
REQ-019 SHALL flag an error when req_addr >= 4*DEPTH_WORDS.
REQ-020 SHALL accept only these store patterns and flag any other as an error:
- 4'b0001<<a, for any a = req_addr[1:0];
- 4'b0011<<a, when a[0]=0;
- 4'b1111, when a=0.
REQ-021 SHALL ignore req_addr[1:0] on loads.
REQ-022 SHALL commit a legal store's enabled bytes on the accept edge; an errored store SHALL leave memory unchanged.
REQ-023 SHALL capture load data at the accept edge and hold it until the response; a load accepted on the cycle after a store to the same word SHALL return the stored data.
REQ-024 SHALL return rsp_rdata=0 for a store and for an error, and SHALL hold rsp_rdata when rsp_valid is low.

Reset
REQ-025 SHALL, on srst high, force IDLE, clear the wait counter, and drive rsp_valid=0, rsp_err=0 and rsp_rdata=0 on the following edge.
REQ-026 SHALL hold req_ready low while srst is high.
REQ-027 SHALL drop an in-flight request when srst is asserted mid-operation, producing no response, while any store already committed SHALL remain.
REQ-028 SHALL NOT clear memory contents on reset.

Configuration
REQ-029 SHALL, with RV_DMEM_WAIT_EN defined, insert WAIT_CYCLES wait states via the WAIT state and a 4-bit counter.
REQ-030 SHALL, without RV_DMEM_WAIT_EN, omit the WAIT state and counter, so latency is fixed at 1 cycle and WAIT_CYCLES is ignored.

Structure
REQ-031 SHALL take from shared package rv_mem_pkg:
- enum dmem_state_e;
- constants WE_NONE, WE_BYTE, WE_HALF and WE_WORD;
- function we_legal(we, addr_lo).
REQ-032 SHALL place storage in one sub-module, rv_dmem_array: four 8-bit byte-lane RAMs with per-lane write enable and a synchronous read port.

Verification
REQ-033 SHALL be covered by these directed scenarios, each run under both macro settings:
- Store req_we=4'b1111, addr 0x10, data 0xDEADBEEF, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, response 1+WAIT_CYCLES cycles after each accept.
- Store req_we=4'b0100, addr 0x12, data 0x00AB0000 onto 0xDEADBEEF, then load 0x10 -> 0xDEABBEEF.
- Store req_we=4'b0011, addr 0x13 -> rsp_err=1; a following load of 0x10 returns unchanged data.
- Load addr 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1, rsp_rdata=0.
- WAIT_CYCLES=0, req_valid held high for 4 back-to-back loads -> 4 consecutive rsp_valid cycles, req_ready never low.
- WAIT_CYCLES=3, srst pulsed in the second WAIT cycle -> no rsp_valid, req_ready low during srst, IDLE afterwards, prior store data intact.
